snake_frame_scheduler: RTL and testbench

// Sequences the Snake game engine against the 640x480 VGA scan. It derives the game tick

---
 rtl/snake_frame_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_snake_frame_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_frame_scheduler.sv
// snake_frame_scheduler
//   Sequences the Snake game engine against the 640x480 VGA scan. It derives the game
//   tick from frame boundaries and hands the shared grid RAM to the game writer only
//   during vertical blanking. The VGA reader owns the RAM at all other times.
//
// Ports
//   clock_25   in   25 MHz pixel clock
//   KEY        in   asynchronous active-low reset
//   X, Y       in   pixel column / line from vga_wrapper
//   speed      in   tick period select, BASE_DIV >> speed frames
//   pause      in   level, suppresses game_tick
//   step       in   (SCHED_STEP_EN only) while paused, a rising edge arms one tick
//   upd_req    in   game engine requests grid RAM write access
//   upd_done   in   1-cycle pulse, game engine finished while granted
//   game_tick  out  1-cycle pulse, one cycle after the frame boundary
//   upd_grant  out  game engine owns grid RAM
//   vga_sel    out  VGA reader owns grid RAM (always ~upd_grant)
//   frame_cnt  out  free-running frame counter
//   overrun    out  sticky, a grant was force-revoked at end of blanking
//
// Configuration macro: SCHED_STEP_EN adds the single-step input.

module snake_frame_scheduler #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned BASE_DIV    = 16,
    parameter int unsigned GUARD_LINES = 4
) (
    input  logic       clock_25,
    input  logic       KEY,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic [1:0] speed,
    input  logic       pause,
`ifdef SCHED_STEP_EN
    input  logic       step,
`endif
    input  logic       upd_req,
    input  logic       upd_done,
    output logic       game_tick,
    output logic       upd_grant,
    output logic       vga_sel,
    output logic [7:0] frame_cnt,
    output logic       overrun
);

    localparam int unsigned DIV_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam int unsigned PER_W = DIV_W + 1;
    localparam int unsigned FC_W  = 8;

    // Illegal timing parameters disable the writer path rather than risk a grant
    // overlapping active video.
    localparam bit PARAMS_OK = (BASE_DIV >= 8) && (H_ACTIVE < H_TOTAL) &&
                               (V_ACTIVE < V_TOTAL) && (GUARD_LINES < (V_TOTAL - V_ACTIVE));

    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_BLANK  = 2'd1,
        S_GRANT  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick_q, tick_d;
    logic              grant_q, grant_d;
    logic              vga_sel_q, vga_sel_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              overrun_q, overrun_d;

    logic              vb_start_c;
    logic              vb_end_c;
    logic              late_c;
    logic [PER_W-1:0]  period_c;
    logic              at_term_c;
    logic              force_tick_c;

    // Scan events decoded from the pixel counters.
    always_comb begin
        vb_start_c = (Y == 10'(V_ACTIVE)) && (X == 10'd0);
        vb_end_c   = (Y == 10'(V_TOTAL - 1)) && (X == 10'(H_TOTAL - 1));
        late_c     = (Y > 10'(V_TOTAL - 1 - GUARD_LINES));
        period_c   = PER_W'(BASE_DIV >> speed);
        // >= rather than == so a shortened period after a speed change still fires.
        at_term_c  = ({1'b0, div_q} >= (period_c - PER_W'(1)));
    end

`ifdef SCHED_STEP_EN
    logic step_prev_q, step_prev_d;
    logic armed_q, armed_d;

    // Rising edges of step while paused collapse into one pending tick.
    always_comb begin
        step_prev_d = step;
        armed_d     = armed_q;
        if (vb_start_c) begin
            armed_d = 1'b0;
        end
        if (pause && step && !step_prev_q) begin
            armed_d = 1'b1;
        end
        force_tick_c = armed_q;
    end

    always_ff @(posedge clock_25 or negedge KEY) begin
        if (!KEY) begin
            step_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            step_prev_q <= step_prev_d;
            armed_q     <= armed_d;
        end
    end
`else
    always_comb begin
        force_tick_c = 1'b0;
    end
`endif

    // Frame counter and tick divider, both advanced only at the start of blanking.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        div_d       = div_q;
        tick_d      = 1'b0;
        if (vb_start_c) begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
            if (force_tick_c) begin
                tick_d = 1'b1;
                div_d  = '0;
            end else if (at_term_c) begin
                // Paused: hold at the terminal count so the tick follows the unpause.
                if (!pause) begin
                    tick_d = 1'b1;
                    div_d  = '0;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // RAM arbitration: at most one grant per frame, only inside blanking.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        overrun_d = overrun_q;
        case (state_q)
            S_ACTIVE: begin
                grant_d = 1'b0;
                if (vb_start_c) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (vb_end_c) begin
                    state_d = S_ACTIVE;
                end else if (upd_req && !late_c && PARAMS_OK) begin
                    grant_d = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (upd_done) begin
                    grant_d = 1'b0;
                    // A release on the last blanking cycle goes straight back to active.
                    state_d = vb_end_c ? S_ACTIVE : S_DONE;
                end else if (vb_end_c) begin
                    grant_d   = 1'b0;
                    overrun_d = 1'b1;
                    state_d   = S_ACTIVE;
                end
            end
            S_DONE: begin
                if (vb_end_c) begin
                    state_d = S_ACTIVE;
                end
            end
            default: begin
                grant_d = 1'b0;
                state_d = S_ACTIVE;
            end
        endcase
        vga_sel_d = ~grant_d;
    end

    always_ff @(posedge clock_25 or negedge KEY) begin
        if (!KEY) begin
            state_q     <= S_ACTIVE;
            div_q       <= '0;
            tick_q      <= 1'b0;
            grant_q     <= 1'b0;
            vga_sel_q   <= 1'b1;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            grant_q     <= grant_d;
            vga_sel_q   <= vga_sel_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign game_tick = tick_q;
    assign upd_grant = grant_q;
    assign vga_sel   = vga_sel_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_snake_frame_scheduler.sv
// Self-checking bench for snake_frame_scheduler. The scan is compressed: each frame visits
// only the coordinates the scheduler decodes, so many frames fit in a short run.

module tb_snake_frame_scheduler;

    localparam int V_ACT    = 480;
    localparam int BASE_DIV = 16;

    logic       clock_25 = 1'b0;
    logic       KEY;
    logic [9:0] X, Y;
    logic [1:0] speed;
    logic       pause, step, upd_req, upd_done;
    logic       game_tick, upd_grant, vga_sel, overrun;
    logic [7:0] frame_cnt;

    snake_frame_scheduler dut (
        .clock_25  (clock_25),
        .KEY       (KEY),
        .X         (X),
        .Y         (Y),
        .speed     (speed),
        .pause     (pause),
`ifdef SCHED_STEP_EN
        .step      (step),
`endif
        .upd_req   (upd_req),
        .upd_done  (upd_done),
        .game_tick (game_tick),
        .upd_grant (upd_grant),
        .vga_sel   (vga_sel),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
    );

    always #20 clock_25 = ~clock_25;

    typedef struct {
        int tick;
        int fc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tick_cnt = 0;
    int   m_fc, m_div, m_armed, m_step_prev;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fc        = 0;
        m_div       = 0;
        m_armed     = 0;
        m_step_prev = 0;
        sb_q.delete();
    endtask

    // One clock with the given scan position; other inputs are taken as currently set.
    task automatic cyc(input int x, input int y);
        exp_t e;
        int   per;
        @(negedge clock_25);
        X = 10'(x);
        Y = 10'(y);
        e.tick = 0;
        if (y == V_ACT && x == 0) begin
            m_fc = (m_fc + 1) % 256;
            per  = BASE_DIV >> speed;
            if (m_armed != 0) begin
                e.tick  = 1;
                m_div   = 0;
                m_armed = 0;
            end else if (m_div >= per - 1) begin
                if (!pause) begin
                    e.tick = 1;
                    m_div  = 0;
                end
            end else begin
                m_div++;
            end
        end
`ifdef SCHED_STEP_EN
        if (pause && step && (m_step_prev == 0)) m_armed = 1;
        m_step_prev = int'(step);
`endif
        e.fc = m_fc;
        sb_q.push_back(e);
        @(posedge clock_25);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_eq("tick", int'(game_tick), e.tick);
            check_eq("frame_cnt", int'(frame_cnt), e.fc);
        end
        if (game_tick) tick_cnt++;
    endtask

    task automatic frame();
        cyc(5, 100);
        cyc(0, 480);
        cyc(1, 480);
        cyc(798, 524);
        cyc(799, 524);
        cyc(0, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        KEY = 1'b0; X = '0; Y = '0; speed = 2'd0;
        pause = 1'b0; step = 1'b0; upd_req = 1'b0; upd_done = 1'b0;
        model_reset();
        #100;
        @(negedge clock_25);
        KEY = 1'b1;
        check_eq("rst_grant", int'(upd_grant), 0);
        check_eq("rst_vga_sel", int'(vga_sel), 1);
        check_eq("rst_frame_cnt", int'(frame_cnt), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_tick", int'(game_tick), 0);

        // Tick cadence at speed 0 and speed 3.
        tick_cnt = 0;
        repeat (64) frame();
        check_eq("ticks_speed0_64fr", tick_cnt, 4);
        speed = 2'd3;
        tick_cnt = 0;
        repeat (8) frame();
        check_eq("ticks_speed3_8fr", tick_cnt, 4);
        speed = 2'd0;

        // Normal grant and release, no second grant in the same frame.
        cyc(5, 100);
        cyc(0, 480);
        cyc(1, 480);
        upd_req = 1'b1;
        cyc(0, 481);
        check_eq("grant_rise", int'(upd_grant), 1);
        check_eq("grant_vga_sel", int'(vga_sel), 0);
        for (int i = 1; i < 100; i++) cyc(i, 481);
        check_eq("grant_held", int'(upd_grant), 1);
        upd_done = 1'b1;
        cyc(100, 481);
        upd_done = 1'b0;
        check_eq("grant_fall", int'(upd_grant), 0);
        check_eq("release_vga_sel", int'(vga_sel), 1);
        for (int i = 0; i < 10; i++) begin
            cyc(200 + i, 490);
            check_eq("no_regrant", int'(upd_grant), 0);
        end
        cyc(798, 524);
        cyc(799, 524);
        cyc(0, 0);
        check_eq("no_overrun_normal", int'(overrun), 0);
        cyc(0, 480);
        check_eq("next_frame_wait", int'(upd_grant), 0);
        cyc(1, 480);
        check_eq("next_frame_grant", int'(upd_grant), 1);
        upd_done = 1'b1;
        cyc(2, 480);
        upd_done = 1'b0;
        upd_req  = 1'b0;
        check_eq("next_frame_release", int'(upd_grant), 0);
        cyc(799, 524);
        cyc(0, 0);

        // Force-revoke at end of blanking.
        upd_req = 1'b1;
        cyc(5, 100);
        check_eq("no_grant_active", int'(upd_grant), 0);
        cyc(0, 480);
        cyc(1, 480);
        check_eq("ovr_grant", int'(upd_grant), 1);
        cyc(400, 500);
        cyc(798, 524);
        check_eq("ovr_grant_late", int'(upd_grant), 1);
        cyc(799, 524);
        check_eq("revoke_grant", int'(upd_grant), 0);
        check_eq("revoke_vga_sel", int'(vga_sel), 1);
        check_eq("overrun_set", int'(overrun), 1);
        upd_req = 1'b0;
        cyc(0, 0);
        frame();
        check_eq("overrun_sticky", int'(overrun), 1);

        // Asynchronous reset mid-frame, no clock edge needed.
        cyc(300, 200);
        #3;
        KEY = 1'b0;
        #1;
        check_eq("arst_grant", int'(upd_grant), 0);
        check_eq("arst_vga_sel", int'(vga_sel), 1);
        check_eq("arst_frame_cnt", int'(frame_cnt), 0);
        check_eq("arst_overrun", int'(overrun), 0);
        check_eq("arst_tick", int'(game_tick), 0);
        model_reset();
        #50;
        @(negedge clock_25);
        KEY = 1'b1;
        cyc(301, 200);
        cyc(0, 480);
        check_eq("fc_after_reset", int'(frame_cnt), 1);
        cyc(799, 524);
        cyc(0, 0);

        // upd_done coincident with vb_end: normal release, no overrun.
        upd_req = 1'b1;
        cyc(0, 480);
        cyc(1, 480);
        check_eq("tie_grant", int'(upd_grant), 1);
        cyc(798, 524);
        upd_done = 1'b1;
        cyc(799, 524);
        upd_done = 1'b0;
        check_eq("tie_grant_drop", int'(upd_grant), 0);
        check_eq("tie_no_overrun", int'(overrun), 0);
        cyc(0, 0);
        cyc(5, 100);
        cyc(0, 480);
        cyc(1, 480);
        check_eq("regrant_after_tie", int'(upd_grant), 1);
        upd_done = 1'b1;
        cyc(2, 480);
        upd_done = 1'b0;
        upd_req  = 1'b0;
        cyc(799, 524);
        cyc(0, 0);

        // Request raised inside the guard band is refused for the frame.
        cyc(5, 100);
        cyc(0, 480);
        cyc(10, 500);
        upd_req = 1'b1;
        cyc(0, 522);
        check_eq("late_no_grant", int'(upd_grant), 0);
        cyc(1, 523);
        cyc(798, 524);
        check_eq("late_no_grant_end", int'(upd_grant), 0);
        cyc(799, 524);
        cyc(0, 0);
        check_eq("late_vga_sel", int'(vga_sel), 1);
        upd_req = 1'b0;

        // Pause blocks ticks; first frame after unpause ticks.
        pause = 1'b1;
        tick_cnt = 0;
        repeat (40) frame();
        check_eq("pause_no_ticks", tick_cnt, 0);
        pause = 1'b0;
        frame();
        check_eq("unpause_tick", tick_cnt, 1);

`ifdef SCHED_STEP_EN
        // Two step edges in one paused frame give one tick and clear the divider.
        pause = 1'b1;
        tick_cnt = 0;
        cyc(5, 100);
        step = 1'b1; cyc(6, 100);
        step = 1'b0; cyc(7, 100);
        step = 1'b1; cyc(8, 100);
        step = 1'b0;
        cyc(0, 480);
        check_eq("step_tick", int'(game_tick), 1);
        cyc(799, 524);
        cyc(0, 0);
        frame();
        check_eq("step_single", tick_cnt, 1);
        pause = 1'b0;
        repeat (3) frame();
        check_eq("step_div_cleared", tick_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
